// File: rtl/ex_mc_sequencer_pkg.sv
// Shared types and default FPU op map for the EX-stage multi-cycle sequencer.
package ex_mc_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ITOF = 3'd0,
    OP_FTOI = 3'd1,
    OP_FNEG = 3'd2,
    OP_FADD = 3'd3,
    OP_FSUB = 3'd4,
    OP_FMUL = 3'd5,
    OP_FDIV = 3'd6,
    OP_RSVD = 3'd7
  } fpu_op_e;

  // One nibble per opcode, opcode 0 in the least significant nibble.
  localparam logic [31:0] DEF_LAT_TABLE = 32'h0646_6066;
  // Only fdiv reports a meaningful exception (division by zero).
  localparam logic [7:0]  DEF_EXC_MASK  = 8'b0100_0000;

endpackage

// File: rtl/ex_mc_sequencer_if.sv
// Issue / FU / result handshake bundle between the EX stage and the sequencer.
interface ex_mc_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int TAG_W  = 4
);
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [TAG_W-1:0]  issue_tag;
  logic [DATA_W-1:0] fu_result;
  logic              fu_exc;
  logic              fu_aclr;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              res_exc;

  modport master (
    output issue_valid, issue_op, issue_tag, fu_result, fu_exc, res_ready,
    input  issue_ready, fu_aclr, busy, res_valid, res_data, res_tag, res_exc
  );

  modport slave (
    input  issue_valid, issue_op, issue_tag, fu_result, fu_exc, res_ready,
    output issue_ready, fu_aclr, busy, res_valid, res_data, res_tag, res_exc
  );
endinterface

// File: rtl/ex_mc_sequencer_lat_counter.sv
// Down-counter that times the RUN phase; last_o marks the capture edge.
module ex_mc_sequencer_lat_counter #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // Decrement is gated on a non-zero count so the counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/ex_mc_sequencer.sv
// Multi-cycle EX sequencer: per-opcode latency, result capture/hold and pipeline stall.
module ex_mc_sequencer
  import ex_mc_sequencer_pkg::*;
#(
  parameter int                          DATA_W    = 32,
  parameter int                          OP_W      = 3,
  parameter int                          TAG_W     = 4,
  parameter int                          LAT_W     = 4,
  parameter logic [(2**OP_W)*LAT_W-1:0]  LAT_TABLE = DEF_LAT_TABLE,
  parameter logic [(2**OP_W)-1:0]        EXC_MASK  = DEF_EXC_MASK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  ex_mc_sequencer_if.slave  bus
);

  // Table fields are LAT_W wide, so every entry is already within MAX_LAT.
  function automatic logic [LAT_W-1:0] lat_of(input logic [OP_W-1:0] op);
    return LAT_TABLE[int'(op)*LAT_W +: LAT_W];
  endfunction

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] res_data_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic              res_exc_q;
  logic              aclr_q;

  logic              issue_ready_c;
  logic              busy_c;
  logic              accept;
  logic [LAT_W-1:0]  new_lat;
  logic              new_zero;
  logic              last;
  logic              capture;
  logic [TAG_W-1:0]  cap_tag;
  logic              cap_exc;
  logic              aclr_d;

  ex_mc_sequencer_lat_counter #(
    .LAT_W (LAT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (flush),
    .load_i     (accept && !new_zero),
    .load_val_i (new_lat),
    .dec_i      (state_q == S_RUN),
    .last_o     (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Flush wins over everything, including a drain or a capture on the same edge.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = new_zero ? S_HOLD : S_RUN;
        S_RUN:  if (last)   state_d = S_HOLD;
        S_HOLD: begin
          if (accept)
            state_d = new_zero ? S_HOLD : S_RUN;
          else if (bus.res_ready)
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    issue_ready_c = !flush && ((state_q == S_IDLE) ||
                               ((state_q == S_HOLD) && bus.res_ready));
    busy_c        = (state_q == S_RUN) || ((state_q == S_HOLD) && !bus.res_ready);
    accept        = bus.issue_valid && issue_ready_c;
    new_lat       = lat_of(bus.issue_op);
    new_zero      = (new_lat == '0);
    capture       = 1'b0;
    cap_tag       = tag_q;
    cap_exc       = 1'b0;
    if (accept && new_zero) begin
      capture = 1'b1;
      cap_tag = bus.issue_tag;
      cap_exc = bus.fu_exc && EXC_MASK[bus.issue_op];
    end else if ((state_q == S_RUN) && last && !flush) begin
      capture = 1'b1;
      cap_exc = bus.fu_exc && EXC_MASK[op_q];
    end
    aclr_d = (flush && (state_q == S_RUN)) || (capture && cap_exc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= '0;
      tag_q      <= '0;
      res_data_q <= '0;
      res_tag_q  <= '0;
      res_exc_q  <= 1'b0;
      aclr_q     <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.issue_op;
        tag_q <= bus.issue_tag;
      end
      if (flush) begin
        res_exc_q <= 1'b0;
      end else if (capture) begin
        res_data_q <= bus.fu_result;
        res_tag_q  <= cap_tag;
        res_exc_q  <= cap_exc;
      end
      aclr_q <= aclr_d;
    end
  end

  assign bus.issue_ready = issue_ready_c;
  assign bus.busy        = busy_c;
  assign bus.res_valid   = (state_q == S_HOLD);
  assign bus.res_data    = res_data_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.res_exc     = res_exc_q;
  assign bus.fu_aclr     = aclr_q;

endmodule

// File: tb/tb_ex_mc_sequencer.sv
// Bench for ex_mc_sequencer: transaction-level reference model plus directed and random traffic.
module tb_ex_mc_sequencer;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;
  localparam int TAG_W  = 4;
  localparam int LAT_W  = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  ex_mc_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W)) bus ();

  ex_mc_sequencer #(
    .DATA_W    (DATA_W),
    .OP_W      (OP_W),
    .TAG_W     (TAG_W),
    .LAT_W     (LAT_W),
    .LAT_TABLE (32'hF646_6066),
    .EXC_MASK  (8'h40)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // Op map: itof ftoi fneg fadd fsub fmul fdiv, plus a 15-cycle op in slot 7.
  int lat_ref [8] = '{6, 6, 0, 6, 6, 4, 6, 15};
  bit exc_ref [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

  // Reference model: one pending op with remaining edges, and at most one held result.
  bit          m_pend, m_held, m_aclr, m_exc;
  int          m_rem, m_pop;
  logic [3:0]  m_ptag, m_tag;
  logic [31:0] m_data;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] s_valid, s_busy, s_ready, s_aclr, s_exc, s_data, s_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_held = 0; m_aclr = 0; m_exc = 0;
    m_rem = 0; m_pop = 0; m_ptag = '0; m_tag = '0; m_data = '0;
  endtask

  task automatic model_edge();
    bit rdy, acc, aclr_n;
    int L;
    rdy    = !flush && !m_pend && (!m_held || bus.res_ready);
    acc    = bus.issue_valid && rdy;
    aclr_n = 0;
    if (flush) begin
      if (m_pend) aclr_n = 1;
      m_pend = 0;
      m_held = 0;
      m_exc  = 0;
    end else begin
      if (m_held && bus.res_ready) m_held = 0;
      if (m_pend) begin
        m_rem--;
        if (m_rem == 0) begin
          m_pend = 0;
          m_held = 1;
          m_data = bus.fu_result;
          m_tag  = m_ptag;
          m_exc  = bus.fu_exc && exc_ref[m_pop];
          aclr_n = m_exc;
        end
      end
      if (acc) begin
        L = lat_ref[bus.issue_op];
        if (L == 0) begin
          m_held = 1;
          m_data = bus.fu_result;
          m_tag  = bus.issue_tag;
          m_exc  = bus.fu_exc && exc_ref[bus.issue_op];
          aclr_n = m_exc;
        end else begin
          m_pend = 1;
          m_rem  = L;
          m_ptag = bus.issue_tag;
          m_pop  = int'(bus.issue_op);
        end
      end
    end
    m_aclr = aclr_n;
  endtask

  task automatic sample_and_check();
    bit e_ready, e_busy;
    #1;
    s_valid = 32'(bus.res_valid);
    s_busy  = 32'(bus.busy);
    s_ready = 32'(bus.issue_ready);
    s_aclr  = 32'(bus.fu_aclr);
    s_exc   = 32'(bus.res_exc);
    s_data  = bus.res_data;
    s_tag   = 32'(bus.res_tag);
    e_ready = !flush && !m_pend && (!m_held || bus.res_ready);
    e_busy  = m_pend || (m_held && !bus.res_ready);
    chk("issue_ready", s_ready, 32'(e_ready));
    chk("busy",        s_busy,  32'(e_busy));
    chk("res_valid",   s_valid, 32'(m_held));
    chk("fu_aclr",     s_aclr,  32'(m_aclr));
    if (m_held) begin
      chk("res_data", s_data, m_data);
      chk("res_tag",  s_tag,  32'(m_tag));
      chk("res_exc",  s_exc,  32'(m_exc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
  endtask

  task automatic step();
    sample_and_check();
    tick();
  endtask

  task automatic issue(input int op, input int tag);
    bus.issue_valid = 1'b1;
    bus.issue_op    = OP_W'(op);
    bus.issue_tag   = TAG_W'(tag);
    step();
    bus.issue_valid = 1'b0;
  endtask

  // Edges counted from the accept edge until res_valid is seen.
  task automatic wait_valid(output int edges, output int busy_cnt);
    bit found;
    edges = 0; busy_cnt = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      sample_and_check();
      if (s_valid == 1) begin
        found = 1;
        break;
      end
      busy_cnt += int'(s_busy);
      tick();
      edges++;
    end
    if (!found) chk("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, bcnt, vcnt;
    bus.issue_valid = 1'b0;
    bus.issue_op    = '0;
    bus.issue_tag   = '0;
    bus.fu_result   = '0;
    bus.fu_exc      = 1'b0;
    bus.res_ready   = 1'b1;
    model_reset();

    // Reset values
    tick(); tick();
    #1;
    chk("rst_busy",      32'(bus.busy),      0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_fu_aclr",   32'(bus.fu_aclr),   0);
    chk("rst_res_data",  bus.res_data,       0);
    rst = 1'b1;
    tick();

    // Async reset in the middle of a fadd (cnt=3)
    bus.fu_result = 32'h1111_2222;
    issue(3, 2);
    step(); step(); step();
    #2 rst = 1'b0;
    #1;
    chk("midrun_busy",      32'(bus.busy),      0);
    chk("midrun_res_valid", 32'(bus.res_valid), 0);
    chk("midrun_fu_aclr",   32'(bus.fu_aclr),   0);
    chk("midrun_res_tag",   32'(bus.res_tag),   0);
    chk("midrun_res_data",  bus.res_data,       0);
    chk("midrun_res_exc",   32'(bus.res_exc),   0);
    tick();
    rst = 1'b1;
    sample_and_check();
    chk("post_rst_ready", s_ready, 1);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sample_and_check();
      vcnt += int'(s_valid);
    end
    chk("post_rst_no_result", 32'(vcnt), 0);

    // fmul, L=4
    bus.res_ready = 1'b1;
    bus.fu_result = 32'h4080_0000;
    issue(5, 5);
    wait_valid(edges, bcnt);
    chk("fmul_latency",  32'(edges), 4);
    chk("fmul_busy_cyc", 32'(bcnt),  4);
    chk("fmul_tag",      s_tag,      5);
    chk("fmul_data",     s_data,     32'h4080_0000);
    tick();
    sample_and_check();
    chk("fmul_drained", s_valid, 0);
    tick();

    // fneg, L=0, consumer stalls then accepts with a back-to-back fadd
    bus.res_ready = 1'b0;
    bus.fu_result = 32'h1234_5678;
    issue(2, 3);
    for (int i = 0; i < 3; i++) begin
      sample_and_check();
      chk("fneg_valid", s_valid, 1);
      chk("fneg_busy",  s_busy,  1);
      chk("fneg_ready", s_ready, 0);
      chk("fneg_data",  s_data,  32'h1234_5678);
      tick();
    end
    bus.res_ready   = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_op    = 3'd3;
    bus.issue_tag   = 4'd7;
    sample_and_check();
    chk("b2b_ready", s_ready, 1);
    tick();
    bus.issue_valid = 1'b0;
    bus.fu_result   = 32'hCAFE_0003;
    wait_valid(edges, bcnt);
    chk("b2b_latency", 32'(edges), 6);
    chk("b2b_tag",     s_tag,      7);
    chk("b2b_data",    s_data,     32'hCAFE_0003);
    tick();

    // fdiv exception is captured and clears the FU; fadd exception is masked
    bus.fu_exc = 1'b1;
    issue(6, 9);
    wait_valid(edges, bcnt);
    chk("fdiv_latency", 32'(edges), 6);
    chk("fdiv_exc",     s_exc,      1);
    chk("fdiv_aclr",    s_aclr,     1);
    tick();
    sample_and_check();
    chk("fdiv_aclr_off", s_aclr, 0);
    issue(3, 4);
    wait_valid(edges, bcnt);
    chk("fadd_exc_masked", s_exc,  0);
    chk("fadd_no_aclr",    s_aclr, 0);
    tick();
    sample_and_check();
    chk("fadd_no_aclr2", s_aclr, 0);
    bus.fu_exc = 1'b0;
    tick();

    // Flush at cnt=2 with a competing issue
    issue(3, 1);
    step(); step(); step(); step();
    flush           = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_op    = 3'd2;
    sample_and_check();
    chk("flush_blocks_issue", s_ready, 0);
    tick();
    flush           = 1'b0;
    bus.issue_valid = 1'b0;
    sample_and_check();
    chk("flush_aclr",  s_aclr,  1);
    chk("flush_busy",  s_busy,  0);
    chk("flush_valid", s_valid, 0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      sample_and_check();
      vcnt += int'(s_valid);
    end
    chk("flush_no_result", 32'(vcnt), 0);
    tick();

    // Maximum latency entry, then a second op issued on the drain cycle
    bus.fu_result = 32'h0000_00AA;
    issue(7, 10);
    wait_valid(edges, bcnt);
    chk("max_lat_latency", 32'(edges), 15);
    chk("max_lat_tag",     s_tag,      10);
    bus.issue_valid = 1'b1;
    bus.issue_op    = 3'd5;
    bus.issue_tag   = 4'd11;
    bus.fu_result   = 32'h0000_00BB;
    sample_and_check();
    chk("second_ready", s_ready, 1);
    tick();
    bus.issue_valid = 1'b0;
    wait_valid(edges, bcnt);
    chk("second_latency", 32'(edges), 4);
    chk("second_tag",     s_tag,      11);
    chk("second_data",    s_data,     32'h0000_00BB);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_op    = OP_W'($urandom_range(0, 7));
      bus.issue_tag   = TAG_W'($urandom_range(0, 15));
      bus.res_ready   = ($urandom_range(0, 9) < 6);
      flush           = ($urandom_range(0, 24) == 0);
      bus.fu_result   = $urandom;
      bus.fu_exc      = 1'($urandom_range(0, 1));
      step();
    end
    flush           = 1'b0;
    bus.issue_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
